// File: rtl/dwpe_mac_array.sv
// Depthwise-convolution MAC array. POX signed lanes share one weight per tap,
// accumulate a runtime-selected number of taps on top of a per-channel bias,
// clamp every partial sum to ACCW bits and present the window result on a
// valid/ready port. A new window may start on the edge that drains the old one.
module dwpe_mac_array #(
  parameter int POX      = 6,
  parameter int DW       = 16,
  parameter int ACCW     = 32,
  parameter int NTAP_MAX = 9,
  parameter int CW       = $clog2(NTAP_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CW-1:0]       cfg_ntap,
  input  logic                cfg_relu,
  input  logic [ACCW-1:0]     bias,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [POX*DW-1:0]   pixel_in,
  input  logic [DW-1:0]       weight_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [POX*ACCW-1:0] out_data,
  output logic [POX-1:0]      out_sat,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [CW-1:0]   NTAP_MAX_C = CW'(NTAP_MAX);
  localparam logic [ACCW-1:0] ACC_MAX    = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MIN    = {1'b1, {(ACCW-1){1'b0}}};

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   ntap_q;
  logic            relu_q;
  logic [ACCW-1:0] acc     [POX];
  logic [ACCW-1:0] acc_nxt [POX];
  logic [POX-1:0]  sat_q;
  logic [POX-1:0]  ovf;
  logic [CW-1:0]   ntap_eff;
  logic [CW-1:0]   cnt_inc;
  logic [2*DW-1:0] wgt_x;
  logic            accept;
  logic            first;

  // In HOLD a tap may only enter when the pending result leaves on the same edge.
  assign in_ready  = rst_n && ((state == HOLD) ? out_ready : 1'b1);
  assign accept    = in_valid && in_ready;
  // Any tap accepted outside ACC opens a new window (from IDLE, or overlapped in HOLD).
  assign first     = accept && (state != ACC);
  assign cnt_inc   = cnt + CW'(1);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_sat   = sat_q;
  assign wgt_x     = {{DW{weight_in[DW-1]}}, weight_in};

  // Map the requested tap count into the supported 1..NTAP_MAX range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it
    // unassigned and infer a latch.
    ntap_eff = cfg_ntap;
    if (cfg_ntap == '0) begin
      ntap_eff = CW'(1);
    end else if (cfg_ntap > NTAP_MAX_C) begin
      ntap_eff = NTAP_MAX_C;
    end
  end

  // Per-lane datapath: full-width product, one-bit-wider sum, clamp, output ReLU.
  for (genvar g = 0; g < POX; g++) begin : g_lane
    logic [2*DW-1:0] pix_x;
    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] base;
    logic [ACCW:0]   sum;

    // Operands are sign-extended to 2*DW so the low 2*DW bits are the signed product.
    assign pix_x = {{DW{pixel_in[g*DW+DW-1]}}, pixel_in[g*DW +: DW]};
    assign prod  = pix_x * wgt_x;
    assign base  = first ? bias : acc[g];
    assign sum   = {base[ACCW-1], base} + {{(ACCW+1-2*DW){prod[2*DW-1]}}, prod};
    // The two top bits disagree exactly when the sum left the ACCW range.
    assign ovf[g]     = sum[ACCW] ^ sum[ACCW-1];
    assign acc_nxt[g] = ovf[g] ? (sum[ACCW] ? ACC_MIN : ACC_MAX) : sum[ACCW-1:0];
    assign out_data[g*ACCW +: ACCW] = (relu_q && acc[g][ACCW-1]) ? '0 : acc[g];
  end

  // Window control FSM: IDLE -> ACC -> HOLD, with overlapped restart out of HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ntap_q <= '0;
      relu_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ntap_q <= ntap_eff;
            relu_q <= cfg_relu;
            cnt    <= CW'(1);
            state  <= (ntap_eff == CW'(1)) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            cnt <= cnt_inc;
            if (cnt_inc == ntap_q) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (accept) begin
              ntap_q <= ntap_eff;
              relu_q <= cfg_relu;
              cnt    <= CW'(1);
              state  <= (ntap_eff == CW'(1)) ? HOLD : ACC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accumulators and sticky saturation flags advance only on accepted taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator array is a handful of flops, not a RAM, so it is
      // reset like any other register to give a known out_data after reset.
      for (int i = 0; i < POX; i++) begin
        acc[i] <= '0;
      end
      sat_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < POX; i++) begin
        acc[i] <= acc_nxt[i];
      end
      sat_q <= first ? ovf : (sat_q | ovf);
    end
  end

endmodule

// File: tb/tb_dwpe_mac_array.sv
// Self-checking bench for dwpe_mac_array: reset values, a table of single
// windows with fixed expectations, hand-written multi-cycle sequences and a
// randomized run scored against an integer reference model of the windows.
module tb_dwpe_mac_array;

  localparam int POX      = 6;
  localparam int DW       = 16;
  localparam int ACCW     = 32;
  localparam int NTAP_MAX = 9;
  localparam int CW       = $clog2(NTAP_MAX + 1);
  localparam int VW       = POX * ACCW;
  localparam longint AMAX = (longint'(1) <<< (ACCW - 1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (ACCW - 1));
  localparam int NV       = 10;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CW-1:0]       cfg_ntap;
  logic                cfg_relu;
  logic [ACCW-1:0]     bias;
  logic                in_valid;
  logic                in_ready;
  logic [POX*DW-1:0]   pixel_in;
  logic [DW-1:0]       weight_in;
  logic                out_valid;
  logic                out_ready;
  logic [POX*ACCW-1:0] out_data;
  logic [POX-1:0]      out_sat;
  logic                busy;

  dwpe_mac_array #(
    .POX(POX), .DW(DW), .ACCW(ACCW), .NTAP_MAX(NTAP_MAX), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_ntap(cfg_ntap), .cfg_relu(cfg_relu),
    .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_in(pixel_in), .weight_in(weight_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model: whole windows in plain integers ----------
  int             m_left = 0;
  bit             m_relu;
  longint         m_acc [POX];
  bit [POX-1:0]   m_sat;
  logic [VW-1:0]  q_data [$];
  logic [POX-1:0] q_sat  [$];

  function automatic void model_reset();
    m_left = 0;
    q_data.delete();
    q_sat.delete();
  endfunction

  function automatic void model_tap(input int ntap, input bit relu, input longint b,
                                    input logic [POX*DW-1:0] pix, input longint w);
    logic [VW-1:0] d;
    longint s, v;
    if (m_left == 0) begin
      m_left = (ntap == 0) ? 1 : (ntap > NTAP_MAX ? NTAP_MAX : ntap);
      m_relu = relu;
      m_sat  = '0;
      for (int i = 0; i < POX; i++) m_acc[i] = b;
    end
    for (int i = 0; i < POX; i++) begin
      s = m_acc[i] + longint'($signed(pix[i*DW +: DW])) * w;
      if (s > AMAX) begin s = AMAX; m_sat[i] = 1'b1; end
      if (s < AMIN) begin s = AMIN; m_sat[i] = 1'b1; end
      m_acc[i] = s;
    end
    m_left--;
    if (m_left == 0) begin
      for (int i = 0; i < POX; i++) begin
        v = (m_relu && m_acc[i] < 0) ? 0 : m_acc[i];
        d[i*ACCW +: ACCW] = v[ACCW-1:0];
      end
      q_data.push_back(d);
      q_sat.push_back(m_sat);
    end
  endfunction

  // ---------------- helpers ---------------------------------------------------
  function automatic logic [VW-1:0] acc_vec(input longint v [POX]);
    logic [VW-1:0] r;
    longint t;
    for (int i = 0; i < POX; i++) begin
      t = v[i];
      r[i*ACCW +: ACCW] = t[ACCW-1:0];
    end
    return r;
  endfunction

  function automatic logic [POX*DW-1:0] pix_vec(input longint v [POX]);
    logic [POX*DW-1:0] r;
    longint t;
    for (int i = 0; i < POX; i++) begin
      t = v[i];
      r[i*DW +: DW] = t[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] acc_all(input longint v);
    longint a [POX];
    for (int i = 0; i < POX; i++) a[i] = v;
    return acc_vec(a);
  endfunction

  function automatic logic [POX*DW-1:0] pix_all(input longint v);
    longint a [POX];
    for (int i = 0; i < POX; i++) a[i] = v;
    return pix_vec(a);
  endfunction

  task automatic drive(input bit v, input int ntap, input bit relu, input longint b,
                       input logic [POX*DW-1:0] pix, input longint w);
    in_valid  = v;
    cfg_ntap  = CW'(ntap);
    cfg_relu  = relu;
    bias      = b[ACCW-1:0];
    pixel_in  = pix;
    weight_in = w[DW-1:0];
  endtask

  // One clock: score a handshake on the result port, feed an accepted tap to the
  // model, then check out_valid against the model on the falling edge.
  task automatic tick();
    bit acc_now, take_now, c_relu;
    int c_ntap;
    longint c_bias, c_w;
    logic [POX*DW-1:0] c_pix;
    #1;
    acc_now  = rst_n && in_valid && in_ready;
    take_now = out_valid && out_ready;
    c_ntap   = int'(cfg_ntap);
    c_relu   = cfg_relu;
    c_bias   = longint'($signed(bias));
    c_w      = longint'($signed(weight_in));
    c_pix    = pixel_in;
    if (take_now && q_data.size() != 0) begin
      check("result_data", out_data, q_data[0]);
      check("result_sat", VW'(out_sat), VW'(q_sat[0]));
      void'(q_data.pop_front());
      void'(q_sat.pop_front());
    end
    @(posedge clk);
    if (acc_now) model_tap(c_ntap, c_relu, c_bias, c_pix, c_w);
    @(negedge clk);
    check("out_valid", VW'(out_valid), VW'(q_data.size() != 0));
  endtask

  // ---------------- single-window vector table --------------------------------
  typedef struct {
    int                ntap;
    bit                relu;
    longint            b;
    longint            w;
    logic [POX*DW-1:0] pix;
    int                taps;
    logic [VW-1:0]     exp;
    logic [POX-1:0]    exp_sat;
  } vec_t;

  vec_t vt [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    longint tmp [POX];
    logic [VW-1:0] held;

    vt[0] = '{9, 1'b0, -100, 1, pix_all(5), 9, acc_all(-55), 6'b000000};
    vt[1] = '{9, 1'b1, -100, 1, pix_all(5), 9, acc_all(0), 6'b000000};
    tmp = '{32767, -32768, 0, 0, 0, 0};
    vt[2].pix = pix_vec(tmp);
    tmp = '{AMAX, AMIN, 0, 0, 0, 0};
    vt[2] = '{9, 1'b0, 0, 32767, vt[2].pix, 9, acc_vec(tmp), 6'b000011};
    tmp = '{1, 2, 3, 4, 5, 6};
    vt[3].pix = pix_vec(tmp);
    tmp = '{5, 3, 1, -1, -3, -5};
    vt[3] = '{1, 1'b0, 7, -2, vt[3].pix, 1, acc_vec(tmp), 6'b000000};
    tmp = '{5, 3, 1, 0, 0, 0};
    vt[4] = '{1, 1'b1, 7, -2, vt[3].pix, 1, acc_vec(tmp), 6'b000000};
    tmp = '{0, 1, 2, 3, 4, 5};
    vt[5].pix = pix_vec(tmp);
    tmp = '{0, 10, 20, 30, 40, 50};
    vt[5] = '{0, 1'b0, 0, 10, vt[5].pix, 1, acc_vec(tmp), 6'b000000};
    vt[6] = '{15, 1'b0, 0, 1, pix_all(1), 9, acc_all(9), 6'b000000};
    vt[7] = '{2, 1'b0, 2147483600, 100, pix_all(1), 2, acc_all(AMAX), 6'b111111};
    vt[8] = '{1, 1'b1, AMIN, 1, pix_all(-1), 1, acc_all(0), 6'b111111};
    tmp = '{10, 20, 30, 0, 5, 100};
    vt[9].pix = pix_vec(tmp);
    tmp = '{20, 0, 0, 50, 35, 0};
    vt[9] = '{3, 1'b1, 50, -1, vt[9].pix, 3, acc_vec(tmp), 6'b000000};

    // ---- reset state
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 4, 1'b0, 0, '0, 0);
    #1;
    check("rst_in_ready", VW'(in_ready), VW'(0));
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_sat", VW'(out_sat), VW'(0));
    check("rst_busy", VW'(busy), VW'(0));
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // ---- table of single windows
    for (int k = 0; k < NV; k++) begin
      for (int t = 0; t < vt[k].taps; t++) begin
        drive(1'b1, vt[k].ntap, vt[k].relu, vt[k].b, vt[k].pix, vt[k].w);
        out_ready = 1'b0;
        tick();
        check($sformatf("vec%0d_valid_tap%0d", k, t), VW'(out_valid), VW'(t == vt[k].taps - 1));
      end
      in_valid = 1'b0;
      check($sformatf("vec%0d_data", k), out_data, vt[k].exp);
      check($sformatf("vec%0d_sat", k), VW'(out_sat), VW'(vt[k].exp_sat));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // ---- basic accumulate: 4 taps, lane i pixel on tap j is i+j+1, weight 3
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < POX; i++) tmp[i] = i + j + 1;
      drive(1'b1, 4, 1'b0, 0, pix_vec(tmp), 3);
      tick();
    end
    in_valid = 1'b0;
    tmp = '{30, 42, 54, 66, 78, 90};
    check("basic_data", out_data, acc_vec(tmp));
    check("basic_sat", VW'(out_sat), VW'(0));
    tick();

    // ---- backpressure with an overlapped restart
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, 2, 1'b0, 0, pix_all(7), 2);
      tick();
    end
    held = acc_all(28);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 2, 1'b0, 1, pix_all(3), 1);
      #1;
      check($sformatf("stall_in_ready_%0d", c), VW'(in_ready), VW'(0));
      check($sformatf("stall_data_%0d", c), out_data, held);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", VW'(in_ready), VW'(1));
    tick();
    check("release_busy", VW'(busy), VW'(1));
    tick();
    in_valid = 1'b0;
    check("overlap_data", out_data, acc_all(7));
    tick();

    // ---- ntap 0 streamed: one result per cycle
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 0, 1'b0, longint'($urandom_range(0, 200)) - 100,
            {$urandom, $urandom, $urandom}, longint'($signed(16'($urandom))));
      tick();
      check($sformatf("ntap0_valid_%0d", c), VW'(out_valid), VW'(1));
    end
    in_valid = 1'b0;
    tick();

    // ---- reset in the middle of a window
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, 4, 1'b0, 1000, pix_all(20000), 50);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", VW'(out_valid), VW'(0));
    check("midrst_out_data", out_data, '0);
    check("midrst_busy", VW'(busy), VW'(0));
    check("midrst_in_ready", VW'(in_ready), VW'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 4, 1'b0, 10, pix_all(1), 1);
      tick();
    end
    in_valid = 1'b0;
    check("postrst_data", out_data, acc_all(14));
    out_ready = 1'b1;
    tick();

    // ---- randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      longint b;
      b = ($urandom_range(0, 1) == 1) ? longint'(int'($urandom))
                                       : longint'($urandom_range(0, 2000)) - 1000;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 15), 1'($urandom_range(0, 1)), b,
            {$urandom, $urandom, $urandom}, longint'($signed(16'($urandom))));
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && out_valid; n++) tick();
    check("drain_out_valid", VW'(out_valid), VW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dwpe_mac_array.md
# dwpe_mac_array

Parametrised depthwise-convolution MAC array: POX parallel signed lanes share one weight per tap and accumulate a runtime-configurable number of taps (1..NTAP_MAX, i.e. kernels up to 3x3 by default). Each window is seeded with a per-channel bias. The result passes an optional ReLU and is clamped to ACCW bits. Results leave through a valid/ready output port with backpressure, and a new window can start in the same cycle the previous result is taken. The block sits between the line-buffer/shift-register pixel feeder and the depthwise output writer.

## Interface
- POX, 6, number of parallel output-pixel lanes
- DW, 16, signed pixel and weight width
- ACCW, 32, signed accumulator/result width; must be at least 2*DW
- NTAP_MAX, 9, maximum taps per window
- CW, $clog2(NTAP_MAX+1), tap-count width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_ntap  in  CW  taps per window; sampled on the first tap of a window
- cfg_relu  in  1  ReLU enable; sampled on the first tap
- bias  in  ACCW  signed bias; sampled on the first tap
- in_valid  in  1  tap data valid
- in_ready  out  1  block can accept a tap
- pixel_in  in  POX*DW  lane i at bits [i*DW +: DW], signed
- weight_in  in  DW  signed weight shared by all lanes
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  POX*ACCW  lane i at bits [i*ACCW +: ACCW], signed
- out_sat  out  POX  per-lane sticky saturation flag for this window
- busy  out  1  high in ACC or HOLD

## Operation
- Tap accept: in_valid && in_ready at a rising edge.
- States: IDLE, ACC, HOLD.
- IDLE:
  - in_ready=1.
  - On accept: latch ntap_eff, cfg_relu, and the tap counter.
  - acc[i] = sat(bias + pixel_i*weight); sat flags are cleared, then set from this add.
  - Go to HOLD if ntap_eff==1, else go to ACC with cnt=1.
- ACC:
  - in_ready=1.
  - On accept: acc[i] = sat(acc[i] + pixel_i*weight); cnt++.
  - When cnt reaches ntap_eff, go to HOLD.
  - Idle cycles (in_valid=0) hold all state.
- HOLD:
  - out_valid=1; in_ready=out_ready.
  - On out_ready with no accept: go to IDLE.
  - On out_ready with an accept: the accepted tap is the first tap of a new window (IDLE rules apply). Go to ACC, or stay in HOLD if ntap_eff==1.
- ntap_eff:
  - cfg_ntap==0 becomes 1.
  - cfg_ntap>NTAP_MAX becomes NTAP_MAX.
- Arithmetic:
  - Product is the full 2*DW signed product, sign-extended to ACCW+1.
  - The sum is computed in ACCW+1 bits, then clamped to [-2^(ACCW-1), 2^(ACCW-1)-1].
  - The lane's out_sat is set on any clamp in the window.
- Output: out_data[i] = (relu && acc[i]<0) ? 0 : acc[i]. ReLU is applied at the output only.
- cfg_*, bias, pixel_in and weight_in are ignored unless a tap is accepted.

## Timing
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, acc=0.
  - out_valid=0, out_data=0, out_sat=0, busy=0.
  - in_ready=0 while rst_n is low.
- Reset mid-window: the partial window is discarded. After release, the first accepted tap starts a fresh window.
- Latency: out_valid rises on the clock edge that accepts the ntap_eff-th tap. The result is visible in the following cycle.
- out_data and out_sat are stable while out_valid=1 && out_ready=0.
- out_valid deasserts on the edge where out_ready=1, unless that edge also completes a 1-tap window.
- in_ready depends combinationally on out_ready (in HOLD only). No other combinational paths.
- Throughput:
  - One tap per cycle.
  - A continuous stream with out_ready=1 produces one result per ntap_eff cycles, with no bubble between windows.
  - ntap_eff==1 gives one result per cycle.

## Test plan
- Basic accumulate:
  - Stimulus: POX=6, DW=16, ACCW=32; ntap=4, bias=0, relu=0, weight=3; tap j, lane i pixel = i+j+1; out_ready=1.
  - Required: one cycle after the 4th accept, out_valid=1 and lane i = 3*(4i+10) (30, 42, 54, 66, 78, 90); out_sat=0.
- Bias and ReLU:
  - Stimulus: ntap=9, bias=-100, weight=1, pixel=5.
  - Required: relu=0 gives -55 on every lane; relu=1 gives 0 on every lane.
- Backpressure and overlap:
  - Stimulus: after a result, hold out_ready=0 for 5 cycles with in_valid=1, then raise out_ready.
  - Required: during the stall, in_ready=0 and out_data is unchanged. On release, the old result is consumed and tap 1 of the next window is accepted on the same edge.
- Saturation:
  - Stimulus: ntap=9, weight=32767, pixel=32767 on lane 0 and -32768 on lane 1.
  - Required: lane 0 = 2147483647 with out_sat[0]=1; lane 1 = -2147483648 with out_sat[1]=1; other lanes 0 with out_sat=0.
- Config edges:
  - Stimulus: cfg_ntap=0 streamed 10 cycles with out_ready=1; then cfg_ntap=15.
  - Required: ntap=0 gives 10 results on 10 consecutive cycles; ntap=15 completes after exactly 9 taps.
- Reset mid-window:
  - Stimulus: pulse rst_n low after 2 of 4 taps.
  - Required: out_valid=0 and out_data=0 immediately. The next 4 taps yield a result free of earlier contributions.
